lsu_arbiter: RTL and testbench
==============================

# lsu_arbiter

Two-port front end for the load-store unit. It shares the single LSU memory/IO port between the CPU memory stage (port C) and a DMA/debug master (port D). Each side uses a valid/ready request channel and a valid/ready response channel. The block keeps one access outstanding at a time and passes it to the LSU through a registered issue slot. Port C has fixed priority, and a starvation guard ensures port D is eventually served.

## Interface
- STARVE_LIMIT, 4: consecutive cycles port D may be denied by port C before D is forced to win the next arbitration (1..15).
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_c_req_valid / i_d_req_valid  in  1  request present.
- o_c_req_ready / o_d_req_ready  out  1  request accepted this cycle.
- i_c_addr / i_d_addr  in  32  byte address (DMEM or IO map).
- i_c_wdata / i_d_wdata  in  32  store data.
- i_c_funct3 / i_d_funct3  in  3  access type (LB/LH/LW/LBU/LHU/SB/SH/SW encoding).
- i_c_wren / i_d_wren  in  1  1 = store, 0 = load.
- o_c_rsp_valid / o_d_rsp_valid  out  1  response available.
- i_c_rsp_ready / i_d_rsp_ready  in  1  requester takes the response.
- o_c_rsp_data / o_d_rsp_data  out  32  load data; 0 for stores and errors.
- o_c_rsp_err / o_d_rsp_err  out  1  misaligned access.
- o_lsu_addr  out  32  to LSU i_lsu_addr.
- o_lsu_st_data  out  32  to LSU i_st_data.
- o_lsu_funct3  out  3  to LSU i_funct3.
- o_lsu_wren  out  1  to LSU i_lsu_wren.
- o_lsu_ctrl_valid  out  1  to LSU i_ctrl_valid; LSU kill and bubble are tied 0 by the parent.
- i_lsu_ld_data  in  32  from LSU o_ld_data.

## Operation
- FSM states:
  - IDLE: accept a request.
  - ISSUE: drive the access to the LSU for exactly one cycle.
  - RESP: hold the response until the owner consumes it.
- Arbitration in IDLE:
  - If only one port is valid, that port wins.
  - If both are valid, C wins unless starve_cnt == STARVE_LIMIT, in which case D wins.
  - The ready of the winner is asserted combinationally; the loser's ready stays 0.
  - Ready is 0 in ISSUE and RESP.
- Accept occurs on valid && ready. The winner's addr/wdata/funct3/wren and an owner bit are latched into the issue register, and the FSM moves to ISSUE.
- Starvation counter (4 bits):
  - Increments in each IDLE cycle where D is valid but C is granted.
  - Saturates at STARVE_LIMIT.
  - Clears when D is granted.
  - Holds in ISSUE and RESP.
- ISSUE:
  - o_lsu_* are driven from the issue register, with o_lsu_ctrl_valid = 1 and o_lsu_wren = latched wren.
  - The misalignment flag is computed from the latched request: funct3 001/101 with addr[0] set, or funct3 010 with addr[1:0] ≠ 0.
  - The response register captures:
    - data = 0 if store or misaligned, else i_lsu_ld_data;
    - err = misalignment flag.
  - A misaligned store is still forwarded with wren = 1; the LSU blocks it internally.
  - Next state is RESP.
- RESP:
  - Only the owner's o_*_rsp_valid = 1; its data/err are driven from the response register. The other port's response outputs are 0.
  - On the owner's rsp_ready, the FSM goes to IDLE.
  - If no ready arrives, the response is held indefinitely and data/err stay stable.
- Outside ISSUE: o_lsu_wren = 0 and o_lsu_ctrl_valid = 0. o_lsu_addr/st_data/funct3 keep their last issued values; this avoids address toggling into the LSU.
- Requesters must hold request fields stable while valid && !ready. The arbiter never drops a valid request.

## Timing
- Reset (synchronous): state = IDLE, starve_cnt = 0, and the issue and response registers are 0. All outputs are 0 in the cycle after reset is sampled; readies may then assert combinationally per the arbitration rules.
- Reset asserted in ISSUE or RESP aborts the access. A store that reaches the LSU edge together with reset is still written (LSU behaviour); the response is discarded.
- Latency: accept at edge N, ISSUE during cycle N+1, rsp_valid from cycle N+2.
- Minimum throughput: one access per 3 cycles, when rsp_ready is high in the first RESP cycle.
- The next accept can occur in the cycle after the RESP→IDLE edge. There is no accept in the same cycle as a response handshake.
- Simultaneous C and D valid with starve_cnt < STARVE_LIMIT: C is granted and starve_cnt increments.

## Structure
- Package lsu_arb_pkg holds:
  - state enum (IDLE/ISSUE/RESP);
  - struct lsu_req_t {addr, wdata, funct3, wren};
  - funct3 constants;
  - a misalignment helper function.
- No sub-module required. The arbitration logic is small enough to stay inline.

## Test plan
- C load LW from 0x0000_0010 while DMEM holds 0xDEADBEEF: C ready in cycle 0, o_lsu_ctrl_valid in cycle 1, o_c_rsp_data = 0xDEADBEEF and err = 0 in cycle 2.
- C and D both held valid continuously with STARVE_LIMIT = 4: grants are C, C, C, C, D, C, …; D's rsp is never asserted while C owns the slot.
- D SB 0xA5 to 0x1000_0000 (LEDR): o_lsu_wren is high for exactly one cycle; the D response carries data 0, err 0.
- C LW to 0x0000_0002: o_c_rsp_err = 1, data = 0; a following LW from 0x0 returns the correct word.
- Hold i_c_rsp_ready low for 5 cycles: rsp_valid and data stay stable, no further grants occur, and D's request stays pending. Then assert reset mid-RESP: all outputs are 0 the next cycle.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and helpers for the LSU front-end arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, the request record latched into the issue slot,
// the RISC-V load/store funct3 encodings and the misalignment check.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        wren;
  } lsu_req_t;

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Halfwords need addr[0] clear, words need addr[1:0] clear. Store
  // encodings share the low bits with the loads, so one check covers both.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_arbiter.sv
// Purpose: share one LSU port between CPU (C) and DMA/debug (D) masters, one access outstanding.
// Latency: accept at edge N, LSU sees the access in cycle N+1, response valid from cycle N+2.
// Backpressure: readies only in IDLE; a response is held until its owner's rsp_ready.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_{c,d}_req_*/o_*_ready   request channels (addr, wdata, funct3, wren)
//   o_{c,d}_rsp_*/i_*_ready   response channels (data, err)
//   o_lsu_*, i_lsu_ld_data    single-access interface to the LSU
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_c_req_valid,
  output logic        o_c_req_ready,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic [2:0]  i_c_funct3,
  input  logic        i_c_wren,
  output logic        o_c_rsp_valid,
  input  logic        i_c_rsp_ready,
  output logic [31:0] o_c_rsp_data,
  output logic        o_c_rsp_err,
  input  logic        i_d_req_valid,
  output logic        o_d_req_ready,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_funct3,
  input  logic        i_d_wren,
  output logic        o_d_rsp_valid,
  input  logic        i_d_rsp_ready,
  output logic [31:0] o_d_rsp_data,
  output logic        o_d_rsp_err,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic [2:0]  o_lsu_funct3,
  output logic        o_lsu_wren,
  output logic        o_lsu_ctrl_valid,
  input  logic [31:0] i_lsu_ld_data
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_starve_nxt;
  lsu_req_t         r_issue,  w_issue_nxt;
  logic             r_owner,  w_owner_nxt;   // 0 = C, 1 = D
  logic [31:0]      r_rsp_data, w_rsp_data_nxt;
  logic             r_rsp_err,  w_rsp_err_nxt;

  logic w_starved;
  logic w_grant_c;
  logic w_grant_d;
  logic w_idle;
  logic w_resp;
  logic w_mis;

  // C has fixed priority unless D has been passed over STARVE_LIMIT times.
  assign w_starved = (r_starve_cnt == LP_LIMIT);
  assign w_grant_c = i_c_req_valid && (!i_d_req_valid || !w_starved);
  assign w_grant_d = i_d_req_valid && (!i_c_req_valid ||  w_starved);

  // Readies are masked during reset: an accept in that cycle would be lost.
  assign w_idle = (r_state == ST_IDLE) && !i_reset;
  assign o_c_req_ready = w_idle && w_grant_c;
  assign o_d_req_ready = w_idle && w_grant_d;

  assign w_mis = is_misaligned(r_issue.funct3, r_issue.addr[1:0]);

  always_comb begin
    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve_cnt;
    w_issue_nxt    = r_issue;
    w_owner_nxt    = r_owner;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_err_nxt  = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (o_c_req_ready) begin
          w_issue_nxt = '{addr: i_c_addr, wdata: i_c_wdata,
                          funct3: i_c_funct3, wren: i_c_wren};
          w_owner_nxt = 1'b0;
          w_state_nxt = ST_ISSUE;
          if (i_d_req_valid && (r_starve_cnt < LP_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
          end
        end else if (o_d_req_ready) begin
          w_issue_nxt = '{addr: i_d_addr, wdata: i_d_wdata,
                          funct3: i_d_funct3, wren: i_d_wren};
          w_owner_nxt  = 1'b1;
          w_state_nxt  = ST_ISSUE;
          w_starve_nxt = '0;
        end
      end
      ST_ISSUE: begin
        // Stores and misaligned accesses return zero data.
        w_rsp_data_nxt = (r_issue.wren || w_mis) ? 32'd0 : i_lsu_ld_data;
        w_rsp_err_nxt  = w_mis;
        w_state_nxt    = ST_RESP;
      end
      ST_RESP: begin
        if (r_owner ? i_d_rsp_ready : i_c_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_issue      <= '0;
      r_owner      <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_issue      <= w_issue_nxt;
      r_owner      <= w_owner_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
    end
  end

  // Address/data/funct3 hold the last issued access so the LSU inputs do
  // not toggle between accesses; only the strobes are qualified by ISSUE.
  assign o_lsu_addr       = r_issue.addr;
  assign o_lsu_st_data    = r_issue.wdata;
  assign o_lsu_funct3     = r_issue.funct3;
  assign o_lsu_ctrl_valid = (r_state == ST_ISSUE);
  assign o_lsu_wren       = (r_state == ST_ISSUE) && r_issue.wren;

  assign w_resp        = (r_state == ST_RESP);
  assign o_c_rsp_valid = w_resp && !r_owner;
  assign o_d_rsp_valid = w_resp &&  r_owner;
  assign o_c_rsp_data  = o_c_rsp_valid ? r_rsp_data : 32'd0;
  assign o_d_rsp_data  = o_d_rsp_valid ? r_rsp_data : 32'd0;
  assign o_c_rsp_err   = o_c_rsp_valid && r_rsp_err;
  assign o_d_rsp_err   = o_d_rsp_valid && r_rsp_err;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed stimulus, cycle model and literal checks.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low on port C.
module tb_lsu_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_vld, c_rdy, c_wr, c_rsp_vld, c_rsp_rdy, c_err;
  logic [31:0] c_addr, c_wd, c_rdat;
  logic [2:0]  c_f3;
  logic        d_vld, d_rdy, d_wr, d_rsp_vld, d_rsp_rdy, d_err;
  logic [31:0] d_addr, d_wd, d_rdat;
  logic [2:0]  d_f3;
  logic [31:0] lsu_addr, lsu_st, lsu_ld;
  logic [2:0]  lsu_f3;
  logic        lsu_wren, lsu_ctrl;

  always #5 clk = ~clk;

  lsu_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_c_req_valid(c_vld), .o_c_req_ready(c_rdy), .i_c_addr(c_addr),
    .i_c_wdata(c_wd), .i_c_funct3(c_f3), .i_c_wren(c_wr),
    .o_c_rsp_valid(c_rsp_vld), .i_c_rsp_ready(c_rsp_rdy),
    .o_c_rsp_data(c_rdat), .o_c_rsp_err(c_err),
    .i_d_req_valid(d_vld), .o_d_req_ready(d_rdy), .i_d_addr(d_addr),
    .i_d_wdata(d_wd), .i_d_funct3(d_f3), .i_d_wren(d_wr),
    .o_d_rsp_valid(d_rsp_vld), .i_d_rsp_ready(d_rsp_rdy),
    .o_d_rsp_data(d_rdat), .o_d_rsp_err(d_err),
    .o_lsu_addr(lsu_addr), .o_lsu_st_data(lsu_st), .o_lsu_funct3(lsu_f3),
    .o_lsu_wren(lsu_wren), .o_lsu_ctrl_valid(lsu_ctrl),
    .i_lsu_ld_data(lsu_ld)
  );

  // LSU stand-in: word-granular read-only memory.
  function automatic logic [31:0] lsu_mem(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h0000_0010) return 32'hDEAD_BEEF;
    if (w == 32'h0000_0000) return 32'h1122_3344;
    return w ^ 32'h5A5A_5A5A;
  endfunction
  assign lsu_ld = lsu_mem(lsu_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [138:0] dut_vec();
    return {c_rdy, d_rdy, c_rsp_vld, d_rsp_vld, c_err, d_err, lsu_wren, lsu_ctrl,
            lsu_f3, c_rdat, d_rdat, lsu_addr, lsu_st};
  endfunction

  // ---------------- behavioural model ----------------
  // m_ph counts where the one outstanding access is: 0 none, 1 at the LSU,
  // 2 waiting for the owner to take the response.
  int          m_ph = 0;
  int          m_starve = 0;
  bit          m_on = 0;
  bit          m_own;
  logic [31:0] m_addr, m_wd, m_rdata;
  logic [2:0]  m_f3;
  logic        m_wr, m_rerr;

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = (f3 == 3'b001 || f3 == 3'b101) ? 2 : (f3 == 3'b010 ? 4 : 1);
    return (a % sz) != 0;
  endfunction

  int cyc = 0;
  always @(negedge clk) begin
    logic        ec, ed, cv, dv;
    logic [138:0] ev;
    cyc++;
    ec = 1'b0;
    ed = 1'b0;
    if (m_on) begin
      if (!rst && m_ph == 0) begin
        if (c_vld && d_vld) begin
          ec = (m_starve < LIM);
          ed = !ec;
        end else begin
          ec = c_vld;
          ed = d_vld;
        end
      end
      cv = (m_ph == 2) && !m_own;
      dv = (m_ph == 2) &&  m_own;
      ev = {ec, ed, cv, dv, cv & m_rerr, dv & m_rerr, (m_ph == 1) & m_wr,
            logic'(m_ph == 1), m_f3, cv ? m_rdata : 32'd0, dv ? m_rdata : 32'd0,
            m_addr, m_wd};
      n_tests++;
      if (dut_vec() !== ev) begin
        n_fail++;
        $display("FAIL model_cycle%0d: got 0x%h, expected 0x%h", cyc, dut_vec(), ev);
      end
    end
    if (rst) begin
      m_on = 1; m_ph = 0; m_starve = 0; m_own = 0;
      m_addr = 0; m_wd = 0; m_f3 = 0; m_wr = 0; m_rdata = 0; m_rerr = 0;
    end else if (m_on) begin
      if (m_ph == 0) begin
        if (ec) begin
          m_own = 0; m_addr = c_addr; m_wd = c_wd; m_f3 = c_f3; m_wr = c_wr; m_ph = 1;
          if (d_vld && m_starve < LIM) m_starve++;
        end else if (ed) begin
          m_own = 1; m_addr = d_addr; m_wd = d_wd; m_f3 = d_f3; m_wr = d_wr; m_ph = 1;
          m_starve = 0;
        end
      end else if (m_ph == 1) begin
        m_rerr  = model_mis(m_f3, m_addr);
        m_rdata = (m_wr || m_rerr) ? 32'd0 : lsu_mem(m_addr);
        m_ph    = 2;
      end else if (m_own ? d_rsp_rdy : c_rsp_rdy) begin
        m_ph = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input logic wr);
    if (p) begin d_vld = v; d_addr = a; d_wd = wd; d_f3 = f3; d_wr = wr; end
    else   begin c_vld = v; c_addr = a; c_wd = wd; c_f3 = f3; c_wr = wr; end
  endtask

  // One complete access on port p; returns the response data/err.
  task automatic access(input string name, input bit p, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input logic wr,
                        output logic [31:0] rd, output logic re);
    bit got;
    rd = 'x; re = 'x;
    drive(p, 1'b1, a, wd, f3, wr);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = p ? d_rdy : c_rdy;
      tick();
    end
    if (p) d_vld = 1'b0; else c_vld = 1'b0;
    if (!got) timeout({name, "_accept"});
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (p ? d_rsp_vld : c_rsp_vld) begin
        got = 1;
        rd = p ? d_rdat : c_rdat;
        re = p ? d_err : c_err;
      end
      tick();
    end
    if (!got) timeout({name, "_rsp"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          glog[$];
  int          exp_g[7] = '{0, 0, 0, 0, 1, 0, 1};
  logic [31:0] rd, snap;
  logic        re;

  initial begin
    int  both_rsp, wren_cnt;
    bit  done, seen, acc;
    logic [31:0] st_seen;

    rst = 1'b1;
    c_rsp_rdy = 1'b1; d_rsp_rdy = 1'b1;
    drive(0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 0, 1'b0);
    tick(); tick();
    @(negedge clk);
    check("reset_outputs_zero", 64'(dut_vec() != 0), 64'd0);
    tick();
    rst = 1'b0;

    // T1: C LW from 0x10, exact cycle timing.
    drive(0, 1'b1, 32'h10, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("t1_c_ready_cyc0", c_rdy, 1);
    check("t1_d_ready_cyc0", d_rdy, 0);
    tick();
    c_vld = 1'b0;
    @(negedge clk);
    check("t1_ctrl_valid_cyc1", lsu_ctrl, 1);
    check("t1_lsu_addr_cyc1", lsu_addr, 32'h10);
    @(negedge clk);
    check("t1_rsp_valid_cyc2", c_rsp_vld, 1);
    check("t1_rsp_data_cyc2", c_rdat, 32'hDEAD_BEEF);
    check("t1_rsp_err_cyc2", c_err, 0);
    tick();

    // T2: C and D both held valid; starvation guard forces a D grant.
    drive(0, 1'b1, 32'h10, 32'h0, 3'b010, 1'b0);
    drive(1, 1'b1, 32'h20, 32'h0, 3'b010, 1'b0);
    both_rsp = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (c_vld && c_rdy) glog.push_back(0);
      if (d_vld && d_rdy) glog.push_back(1);
      if (c_rsp_vld && d_rsp_vld) both_rsp++;
      tick();
      if (glog.size() >= 6) c_vld = 1'b0;
      if (glog.size() >= 7) begin d_vld = 1'b0; done = 1; end
    end
    repeat (3) tick();
    check("t2_grant_count", glog.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t2_grant%0d", i), (i < glog.size()) ? glog[i] : 99, exp_g[i]);
    check("t2_overlapping_rsp", both_rsp, 0);

    // T3: D SB 0xA5 to LEDR.
    drive(1, 1'b1, 32'h1000_0000, 32'hA5, 3'b000, 1'b1);
    wren_cnt = 0; seen = 0; st_seen = 0; rd = 'x; re = 'x;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = d_vld && d_rdy;
      if (lsu_wren) begin wren_cnt++; st_seen = lsu_st; end
      if (d_rsp_vld) begin seen = 1; rd = d_rdat; re = d_err; end
      tick();
      if (acc) d_vld = 1'b0;
    end
    check("t3_wren_cycles", wren_cnt, 1);
    check("t3_st_data", st_seen, 32'hA5);
    check("t3_rsp_seen", seen, 1);
    check("t3_rsp_data", rd, 0);
    check("t3_rsp_err", re, 0);

    // T4: misalignment cases.
    access("t4_lw2", 0, 32'h2, 0, 3'b010, 1'b0, rd, re);
    check("t4_lw2_err", re, 1);
    check("t4_lw2_data", rd, 0);
    access("t4_lw0", 0, 32'h0, 0, 3'b010, 1'b0, rd, re);
    check("t4_lw0_err", re, 0);
    check("t4_lw0_data", rd, 32'h1122_3344);
    access("t4_lh1", 0, 32'h1, 0, 3'b001, 1'b0, rd, re);
    check("t4_lh1_err", re, 1);
    access("t4_lhu3", 1, 32'h3, 0, 3'b101, 1'b0, rd, re);
    check("t4_lhu3_err", re, 1);
    access("t4_lb3", 1, 32'h3, 0, 3'b000, 1'b0, rd, re);
    check("t4_lb3_err", re, 0);
    check("t4_lb3_data", rd, 32'h1122_3344);
    access("t4_sw6", 0, 32'h6, 32'h1234, 3'b010, 1'b1, rd, re);
    check("t4_sw6_err", re, 1);
    check("t4_sw6_data", rd, 0);

    // T5: held response, pending D, then reset mid-RESP.
    c_rsp_rdy = 1'b0;
    drive(0, 1'b1, 32'h10, 0, 3'b010, 1'b0);
    acc = 0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = c_rdy;
      tick();
    end
    c_vld = 1'b0;
    if (!acc) timeout("t5_accept");
    drive(1, 1'b1, 32'h20, 0, 3'b010, 1'b0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = c_rsp_vld;
      if (!seen) tick();
    end
    if (!seen) timeout("t5_rsp");
    snap = c_rdat;
    check("t5_snap_data", snap, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("t5_hold_valid%0d", k), c_rsp_vld, 1);
      check($sformatf("t5_hold_data%0d", k), c_rdat, snap);
      check($sformatf("t5_no_grant%0d", k), {c_rdy, d_rdy, lsu_ctrl}, 0);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t5_reset_outputs_zero", 64'(dut_vec() != 0), 64'd0);
    tick();
    rst = 1'b0;
    c_rsp_rdy = 1'b1;
    seen = 0; rd = 'x;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      acc = d_rdy;
      if (d_rsp_vld) begin seen = 1; rd = d_rdat; end
      tick();
      if (acc) d_vld = 1'b0;
    end
    if (!seen) timeout("t5_d_after_reset");
    check("t5_d_data_after_reset", rd, 32'h5A5A_5A7A);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
